br_resolve_unit: RTL
====================

Name: br_resolve_unit

Overview:
Multi-lane branch/jump resolution unit placed after the integer ALU lanes. Each cycle it evaluates up to LANES branch/jump results against their predictions and registers per-lane resolution reports for the ROB and predictor update. It selects the oldest mispredict, relative to the ROB head, and holds it as a redirect request until the frontend acknowledges it.

Parameters:
ADDR, `AddrWidth, address/result width
ROB_DEPTH, `RobDepth, ROB entries (power of 2)
LANES, 2, number of ALU lanes resolved per cycle
ROB, $clog2(ROB_DEPTH), ROB id width (derived, not overridable)

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
flush_  in  1  synchronous active-low pipeline flush (exception/trap)
rob_head  in  ROB  oldest in-flight ROB id
in_valid  in  LANES  lane carries a resolvable inst
in_branch  in  LANES  conditional branch (compare result in alu_res[0])
in_jump  in  LANES  jump (alu_res = computed target)
in_rob_id  in  LANES*ROB  per-lane ROB id
alu_res  in  LANES*ADDR  per-lane ALU result
pred_addr  in  LANES*ADDR  predicted next PC
br_pred  in  LANES  predicted taken
br_target  in  LANES*ADDR  taken target of conditional branch
fall_addr  in  LANES*ADDR  PC+4 of branch
res_valid  out  LANES  registered resolution report valid
res_rob_id  out  LANES*ROB  resolved ROB id
res_taken  out  LANES  actual direction (jumps report 1)
res_miss  out  LANES  lane mispredicted
miss_valid  out  1  redirect request pending
miss_rob_id  out  ROB  ROB id of pending redirect
miss_target  out  ADDR  correct next PC
miss_ack  in  1  frontend accepted redirect

Behaviour:
- Reset (reset_ low, async): res_valid=0, res_rob_id=0, res_taken=0, res_miss=0, miss_valid=0, miss_rob_id=0, miss_target=0, FSM=IDLE.
- Lane eval (comb): taken = alu_res[0]. Branch miss = (br_pred != taken); target = taken ? br_target : fall_addr. Jump miss = (alu_res != pred_addr); target = alu_res. Lanes with in_branch and in_jump both set are treated as jumps. Lanes with in_valid=0, or with neither flag set, are ignored (res_valid=0).
- Report stage: res_* is registered, with 1-cycle latency from inputs. res_rob_id is 0 when res_valid=0.
- Age: age = (rob_id - rob_head) mod ROB_DEPTH, ROB bits unsigned wrap. Smaller age is older. Equal age: the lower lane index wins.
- Candidate: the oldest missing lane in the current cycle.
- FSM IDLE: on a candidate -> PEND next cycle. Load miss_rob_id/miss_target; miss_valid=1. The latency matches the report stage.
- FSM PEND: miss_valid held; miss_rob_id/miss_target stable unless replaced.
  - A candidate strictly older than the pending miss replaces it (stays PEND). Younger or equal candidates are dropped.
  - miss_ack=1 with no older candidate -> IDLE, miss_valid=0 next cycle.
  - miss_ack=1 with an older candidate in the same cycle -> load the candidate, stay PEND.
  - miss_ack is ignored in IDLE.
- flush_ low: next cycle res_valid=0, miss_valid=0, FSM=IDLE. Same-cycle inputs are discarded. flush_ has priority over miss_ack and candidates.
- rob_head is sampled each cycle for comparison, so a pending miss's age is recomputed against the current head.

Optional Feature:
BR_STAT_EN. When defined, adds output ports stat_br (32b) and stat_miss (32b). stat_br counts resolved branches+jumps; stat_miss counts res_miss lanes. Both add up to LANES per cycle, saturate at all-ones, reset to 0 on reset_, and are unaffected by flush_. When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Lane0 branch, br_pred=1, alu_res=1, br_target=0x100 -> next cycle res_valid[0]=1, res_taken[0]=1, res_miss[0]=0, miss_valid=0.
- Lane1 branch, br_pred=0, alu_res=1, br_target=0x200, rob_id=5 -> next cycle miss_valid=1, miss_rob_id=5, miss_target=0x200; held until miss_ack, then 0 the following cycle.
- rob_head=60, ROB_DEPTH=64, lane0 miss rob_id=2, lane1 miss rob_id=62 -> miss_rob_id=62 (wrap-aware oldest).
- PEND with rob_id=10, head=0; new jump miss rob_id=4 target 0x300 together with miss_ack -> stays PEND, miss_rob_id=4, miss_target=0x300. Repeat with rob_id=12 -> IDLE.
- PEND, assert flush_=0 with a new lane miss -> next cycle miss_valid=0, res_valid=0.
- Reset asserted mid-PEND -> all outputs 0 immediately (async), FSM IDLE after release. With BR_STAT_EN: 3 branches with 1 miss -> stat_br=3, stat_miss=1.

Source files
------------

// File: rtl/br_resolve_unit.sv
// Branch/jump resolution unit.
// Resolves up to LANES ALU results per cycle against their predictions and
// registers a per-lane report. The oldest mispredict (measured from the ROB
// head) is held as a redirect request until the frontend acknowledges it.
// Optional build macro BR_STAT_EN adds saturating stat_br/stat_miss counters.
module br_resolve_unit #(
    parameter int unsigned ADDR      = 32,
    parameter int unsigned ROB_DEPTH = 64,
    parameter int unsigned LANES     = 2,
    localparam int unsigned ROB      = $clog2(ROB_DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  flush_,
    input  logic [ROB-1:0]        rob_head,
    input  logic [LANES-1:0]      in_valid,
    input  logic [LANES-1:0]      in_branch,
    input  logic [LANES-1:0]      in_jump,
    input  logic [LANES*ROB-1:0]  in_rob_id,
    input  logic [LANES*ADDR-1:0] alu_res,
    input  logic [LANES*ADDR-1:0] pred_addr,
    input  logic [LANES-1:0]      br_pred,
    input  logic [LANES*ADDR-1:0] br_target,
    input  logic [LANES*ADDR-1:0] fall_addr,
    output logic [LANES-1:0]      res_valid,
    output logic [LANES*ROB-1:0]  res_rob_id,
    output logic [LANES-1:0]      res_taken,
    output logic [LANES-1:0]      res_miss,
    output logic                  miss_valid,
    output logic [ROB-1:0]        miss_rob_id,
    output logic [ADDR-1:0]       miss_target,
    input  logic                  miss_ack
`ifdef BR_STAT_EN
    ,
    output logic [31:0]           stat_br,
    output logic [31:0]           stat_miss
`endif
);

    typedef enum logic {StIdle, StPend} state_t;

    state_t               state;
    logic [LANES-1:0]     act;
    logic [LANES-1:0]     taken;
    logic [LANES-1:0]     miss;
    logic [ADDR-1:0]      tgt [LANES];
    logic [ROB-1:0]       age [LANES];
    logic [LANES*ROB-1:0] rid_next;
    logic                 cand_valid;
    logic [ROB-1:0]       cand_age;
    logic [ROB-1:0]       cand_id;
    logic [ADDR-1:0]      cand_tgt;
    logic [ROB-1:0]       pend_age;

    // Per-lane evaluation; a lane with both flags set resolves as a jump.
    always_comb begin
        rid_next = '0;
        for (int l = 0; l < LANES; l++) begin
            act[l] = in_valid[l] & (in_branch[l] | in_jump[l]);
            if (in_jump[l]) begin
                taken[l] = 1'b1;
                miss[l]  = alu_res[l*ADDR +: ADDR] != pred_addr[l*ADDR +: ADDR];
                tgt[l]   = alu_res[l*ADDR +: ADDR];
            end else begin
                taken[l] = alu_res[l*ADDR];
                miss[l]  = br_pred[l] != alu_res[l*ADDR];
                tgt[l]   = alu_res[l*ADDR] ? br_target[l*ADDR +: ADDR]
                                           : fall_addr[l*ADDR +: ADDR];
            end
            // Unsigned wrap gives the distance from the head modulo ROB_DEPTH.
            age[l] = in_rob_id[l*ROB +: ROB] - rob_head;
            if (act[l]) rid_next[l*ROB +: ROB] = in_rob_id[l*ROB +: ROB];
        end
    end

    // Oldest mispredicting lane; strict compare keeps the lower lane on ties.
    always_comb begin
        cand_valid = 1'b0;
        cand_age   = '0;
        cand_id    = '0;
        cand_tgt   = '0;
        for (int l = 0; l < LANES; l++) begin
            if (act[l] && miss[l] && (!cand_valid || age[l] < cand_age)) begin
                cand_valid = 1'b1;
                cand_age   = age[l];
                cand_id    = in_rob_id[l*ROB +: ROB];
                cand_tgt   = tgt[l];
            end
        end
    end

    // Pending miss age is re-evaluated against the current head every cycle.
    assign pend_age = miss_rob_id - rob_head;

    // Report registers and redirect FSM; flush wins over ack and candidates.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            res_valid   <= '0;
            res_rob_id  <= '0;
            res_taken   <= '0;
            res_miss    <= '0;
            miss_valid  <= 1'b0;
            miss_rob_id <= '0;
            miss_target <= '0;
            state       <= StIdle;
        end else if (!flush_) begin
            res_valid  <= '0;
            res_rob_id <= '0;
            res_taken  <= '0;
            res_miss   <= '0;
            miss_valid <= 1'b0;
            state      <= StIdle;
        end else begin
            res_valid  <= act;
            res_rob_id <= rid_next;
            res_taken  <= act & taken;
            res_miss   <= act & miss;
            unique case (state)
                StIdle: begin
                    if (cand_valid) begin
                        miss_valid  <= 1'b1;
                        miss_rob_id <= cand_id;
                        miss_target <= cand_tgt;
                        state       <= StPend;
                    end
                end
                StPend: begin
                    if (cand_valid && cand_age < pend_age) begin
                        miss_rob_id <= cand_id;
                        miss_target <= cand_tgt;
                    end else if (miss_ack) begin
                        miss_valid <= 1'b0;
                        state      <= StIdle;
                    end
                end
            endcase
        end
    end

`ifdef BR_STAT_EN
    logic [31:0] n_br;
    logic [31:0] n_miss;
    logic [32:0] sum_br;
    logic [32:0] sum_miss;

    // Lanes resolved this cycle, counted regardless of flush.
    always_comb begin
        n_br   = '0;
        n_miss = '0;
        for (int l = 0; l < LANES; l++) begin
            n_br   = n_br + 32'(act[l]);
            n_miss = n_miss + 32'(act[l] & miss[l]);
        end
        sum_br   = {1'b0, stat_br} + {1'b0, n_br};
        sum_miss = {1'b0, stat_miss} + {1'b0, n_miss};
    end

    // Saturating statistics counters.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            stat_br   <= '0;
            stat_miss <= '0;
        end else begin
            stat_br   <= sum_br[32] ? '1 : sum_br[31:0];
            stat_miss <= sum_miss[32] ? '1 : sum_miss[31:0];
        end
    end
`endif

endmodule
